// File: rtl/rd_line_assembler.sv
// Read-return line assembler: queues READ commands, gathers BURST_LEN beats into a line,
// buffers lines in a small FIFO with credit return. Optional macro: RD_ASM_CRITICAL_WORD_FIRST_EN.
module rd_line_assembler #(
    parameter int BURST_LEN  = 8,
    parameter int TAG_W      = 4,
    parameter int CMD_DEPTH  = 4,
    parameter int LINE_DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    rd_en,
    input  logic [TAG_W-1:0]        rd_tag,
    input  logic [$clog2(BURST_LEN)-1:0] rd_col,
    input  logic                    beat_valid,
    input  logic [31:0]             beat_data,
    output logic                    line_valid,
    output logic [32*BURST_LEN-1:0] line_data,
    output logic [TAG_W-1:0]        line_tag,
    input  logic                    line_ready,
    output logic                    rd_credit,
    output logic                    err_unexp,
    output logic                    err_ovf
);

    localparam int COL_W = $clog2(BURST_LEN);
    localparam int CQ_PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CQ_CW = $clog2(CMD_DEPTH + 1);
    localparam int LF_PW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam int LF_CW = $clog2(LINE_DEPTH + 1);
    localparam int LINE_W = 32 * BURST_LEN;

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_t;

    // Command queue
    logic [TAG_W-1:0] cq_tag_mem [CMD_DEPTH];
    logic [CQ_PW-1:0] cq_wr_ptr, cq_rd_ptr;
    logic [CQ_CW-1:0] cq_count;
    logic             cq_empty, cq_full, cq_push;

    // Line FIFO
    logic [LINE_W-1:0] lf_data_mem [LINE_DEPTH];
    logic [TAG_W-1:0]  lf_tag_mem  [LINE_DEPTH];
    logic [LF_PW-1:0]  lf_wr_ptr, lf_rd_ptr;
    logic [LF_CW-1:0]  lf_count;
    logic              lf_full, lf_push, lf_pop;

    // Assembly
    state_t            state_q, state_d;
    logic [COL_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d, line_next;
    logic [COL_W-1:0]  slot;
    logic              beat_accept, complete;

`ifdef RD_ASM_CRITICAL_WORD_FIRST_EN
    logic [COL_W-1:0] cq_col_mem [CMD_DEPTH];
    assign slot = beat_cnt_q + cq_col_mem[cq_rd_ptr];
`else
    logic unused_rd_col;
    assign unused_rd_col = ^rd_col;
    assign slot = beat_cnt_q;
`endif

    function automatic logic [CQ_PW-1:0] cq_inc(input logic [CQ_PW-1:0] p);
        return (p == CQ_PW'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [LF_PW-1:0] lf_inc(input logic [LF_PW-1:0] p);
        return (p == LF_PW'(LINE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cq_empty    = (cq_count == '0);
    assign cq_full     = (cq_count == CQ_CW'(CMD_DEPTH));
    assign lf_full     = (lf_count == LF_CW'(LINE_DEPTH));
    assign beat_accept = beat_valid && !cq_empty;

    // A completing burst frees a CQ slot in the same cycle, so a full CQ can still accept.
    assign cq_push = rd_en && (!cq_full || complete);
    assign lf_pop  = line_valid && line_ready;
    assign lf_push = complete && (!lf_full || lf_pop);

    always_comb begin
        line_next = line_buf_q;
        for (int unsigned k = 0; k < BURST_LEN; k++) begin
            if (slot == COL_W'(k)) line_next[32*k +: 32] = beat_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_buf_d = line_buf_q;
        complete   = 1'b0;
        if (beat_accept) begin
            line_buf_d = line_next;
            case (state_q)
                IDLE: begin
                    beat_cnt_d = COL_W'(1);
                    state_d    = COLLECT;
                end
                COLLECT: begin
                    if (beat_cnt_q == COL_W'(BURST_LEN - 1)) begin
                        complete   = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_buf_q <= '0;
            cq_wr_ptr  <= '0;
            cq_rd_ptr  <= '0;
            cq_count   <= '0;
            lf_wr_ptr  <= '0;
            lf_rd_ptr  <= '0;
            lf_count   <= '0;
            err_unexp  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            line_buf_q <= line_buf_d;
            if (cq_push)  cq_wr_ptr <= cq_inc(cq_wr_ptr);
            if (complete) cq_rd_ptr <= cq_inc(cq_rd_ptr);
            cq_count <= cq_count + CQ_CW'(cq_push) - CQ_CW'(complete);
            if (lf_push) lf_wr_ptr <= lf_inc(lf_wr_ptr);
            if (lf_pop)  lf_rd_ptr <= lf_inc(lf_rd_ptr);
            lf_count <= lf_count + LF_CW'(lf_push) - LF_CW'(lf_pop);
            if (beat_valid && cq_empty) err_unexp <= 1'b1;
            if ((rd_en && !cq_push) || (complete && !lf_push)) err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (cq_push) begin
            cq_tag_mem[cq_wr_ptr] <= rd_tag;
`ifdef RD_ASM_CRITICAL_WORD_FIRST_EN
            cq_col_mem[cq_wr_ptr] <= rd_col;
`endif
        end
        if (lf_push) begin
            lf_data_mem[lf_wr_ptr] <= line_next;
            lf_tag_mem[lf_wr_ptr]  <= cq_tag_mem[cq_rd_ptr];
        end
    end

    assign line_valid = (lf_count != '0);
    assign line_data  = line_valid ? lf_data_mem[lf_rd_ptr] : '0;
    assign line_tag   = line_valid ? lf_tag_mem[lf_rd_ptr]  : '0;
    assign rd_credit  = (32'(cq_count) + 32'(lf_count)) < 32'(LINE_DEPTH);

endmodule

// File: tb/tb_rd_line_assembler.sv
// Directed self-checking bench for rd_line_assembler (default parameters; honours RD_ASM_CRITICAL_WORD_FIRST_EN).
module tb_rd_line_assembler;

    logic         CLK = 1'b0;
    logic         RST;
    logic         rd_en;
    logic [3:0]   rd_tag;
    logic [2:0]   rd_col;
    logic         beat_valid;
    logic [31:0]  beat_data;
    logic         line_valid;
    logic [255:0] line_data;
    logic [3:0]   line_tag;
    logic         line_ready;
    logic         rd_credit;
    logic         err_unexp;
    logic         err_ovf;

    int checks = 0;
    int errors = 0;

    rd_line_assembler #(
        .BURST_LEN (8),
        .TAG_W     (4),
        .CMD_DEPTH (4),
        .LINE_DEPTH(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rd_en     (rd_en),
        .rd_tag    (rd_tag),
        .rd_col    (rd_col),
        .beat_valid(beat_valid),
        .beat_data (beat_data),
        .line_valid(line_valid),
        .line_data (line_data),
        .line_tag  (line_tag),
        .line_ready(line_ready),
        .rd_credit (rd_credit),
        .err_unexp (err_unexp),
        .err_ovf   (err_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] slot_of(input int k);
        return line_data[32*k +: 32];
    endfunction

    task automatic issue(input logic [3:0] tag, input logic [2:0] col);
        rd_en  = 1'b1;
        rd_tag = tag;
        rd_col = col;
        step();
        rd_en  = 1'b0;
    endtask

    task automatic burst(input logic [31:0] base, input logic [31:0] inc);
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1;
            beat_data  = base + inc * 32'(i);
            step();
        end
        beat_valid = 1'b0;
    endtask

    task automatic pop_one();
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_valid"},  256'(line_valid), 256'(0));
        chk({pfx, "_data"},   line_data,        256'(0));
        chk({pfx, "_tag"},    256'(line_tag),   256'(0));
        chk({pfx, "_credit"}, 256'(rd_credit),  256'(1));
        chk({pfx, "_unexp"},  256'(err_unexp),  256'(0));
        chk({pfx, "_ovf"},    256'(err_ovf),    256'(0));
    endtask

    initial begin
        RST = 1'b1; rd_en = 1'b0; rd_tag = '0; rd_col = '0;
        beat_valid = 1'b0; beat_data = '0; line_ready = 1'b0;
        step(); step();
        RST = 1'b0;
        check_reset_outputs("rst");

        // Basic read: tag 3, col 0, beats 0x11111111..0x88888888
        issue(4'd3, 3'd0);
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1;
            beat_data  = 32'h1111_1111 * 32'(i + 1);
            step();
            if (i == 6) chk("basic_not_early", 256'(line_valid), 256'(0));
        end
        beat_valid = 1'b0;
        chk("basic_valid", 256'(line_valid), 256'(1));
        chk("basic_slot0", 256'(slot_of(0)), 256'(32'h1111_1111));
        chk("basic_slot7", 256'(slot_of(7)), 256'(32'h8888_8888));
        chk("basic_tag",   256'(line_tag),   256'(3));
        pop_one();
        chk("basic_popped", 256'(line_valid), 256'(0));

        // Critical word first: col 5, beats 0xB0000000 + i
        issue(4'd5, 3'd5);
        burst(32'hB000_0000, 32'd1);
        chk("cwf_valid", 256'(line_valid), 256'(1));
`ifdef RD_ASM_CRITICAL_WORD_FIRST_EN
        chk("cwf_slot5", 256'(slot_of(5)), 256'(32'hB000_0000));
        chk("cwf_slot7", 256'(slot_of(7)), 256'(32'hB000_0002));
        chk("cwf_slot0", 256'(slot_of(0)), 256'(32'hB000_0003));
        chk("cwf_slot4", 256'(slot_of(4)), 256'(32'hB000_0007));
`else
        chk("cwf_slot0", 256'(slot_of(0)), 256'(32'hB000_0000));
        chk("cwf_slot5", 256'(slot_of(5)), 256'(32'hB000_0005));
`endif
        pop_one();

        // Backpressure and credit
        issue(4'd1, 3'd0);
        chk("bp_credit_one", 256'(rd_credit), 256'(1));
        issue(4'd2, 3'd0);
        chk("bp_credit_zero", 256'(rd_credit), 256'(0));
        burst(32'hA100_0000, 32'd1);
        burst(32'hA200_0000, 32'd1);
        step(); step();
        chk("bp_held_valid",  256'(line_valid), 256'(1));
        chk("bp_held_tag",    256'(line_tag),   256'(1));
        chk("bp_held_slot3",  256'(slot_of(3)), 256'(32'hA100_0003));
        chk("bp_held_credit", 256'(rd_credit),  256'(0));
        line_ready = 1'b1;
        step();
        chk("bp_second_tag",   256'(line_tag),   256'(2));
        chk("bp_second_slot6", 256'(slot_of(6)), 256'(32'hA200_0006));
        chk("bp_credit_back",  256'(rd_credit),  256'(1));
        step();
        line_ready = 1'b0;
        chk("bp_drained", 256'(line_valid), 256'(0));

        // Unexpected beat
        beat_valid = 1'b1; beat_data = 32'hDEAD_BEEF;
        step();
        beat_valid = 1'b0;
        chk("unexp_flag",  256'(err_unexp),  256'(1));
        chk("unexp_noline", 256'(line_valid), 256'(0));
        issue(4'd7, 3'd0);
        burst(32'h7000_0000, 32'h10);
        chk("unexp_after_tag",   256'(line_tag),   256'(7));
        chk("unexp_after_slot0", 256'(slot_of(0)), 256'(32'h7000_0000));
        chk("unexp_after_slot3", 256'(slot_of(3)), 256'(32'h7000_0030));
        chk("unexp_sticky",      256'(err_unexp),  256'(1));
        pop_one();

        // Overflow: five commands into a 4-entry queue
        chk("ovf_clear_before", 256'(err_ovf), 256'(0));
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1; rd_tag = 4'(i); rd_col = '0;
            step();
        end
        rd_en = 1'b0;
        chk("ovf_flag",     256'(err_ovf),      256'(1));
        chk("ovf_cq_count", 256'(dut.cq_count), 256'(4));
        for (int b = 0; b < 4; b++) begin
            burst(32'h5000_0000 + 32'(b << 8), 32'd1);
            chk($sformatf("ovf_drain_tag%0d", b), 256'(line_tag), 256'(b));
            pop_one();
        end
        chk("ovf_drained", 256'(line_valid), 256'(0));

        // Reset mid-burst
        issue(4'd9, 3'd0);
        for (int i = 0; i < 4; i++) begin
            beat_valid = 1'b1; beat_data = 32'hEEEE_0000 + 32'(i);
            step();
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        beat_valid = 1'b0;
        check_reset_outputs("midrst");
        issue(4'd4, 3'd0);
        burst(32'h4000_0000, 32'd1);
        chk("fresh_valid", 256'(line_valid), 256'(1));
        chk("fresh_tag",   256'(line_tag),   256'(4));
        for (int k = 0; k < 8; k++)
            chk($sformatf("fresh_slot%0d", k), 256'(slot_of(k)), 256'(32'h4000_0000 + 32'(k)));
        pop_one();
        chk("fresh_done", 256'(line_valid), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rd_line_assembler.md
# rd_line_assembler

Read-return stage directly downstream of `data_transfer` on the controller read path. It queues each read command as `dram_command` issues it, collects the `BURST_LEN` 32-bit beats returned by `data_transfer`, and assembles them into one cache line. Completed lines go into a small line FIFO and are presented to the requester over a valid/ready handshake. It also returns a credit to the command stage so the line FIFO can never overflow.

## Interface
Parameters:
- `BURST_LEN`, 8: beats per read burst; must be a power of 2 and at least 2.
- `TAG_W`, 4: request tag width.
- `CMD_DEPTH`, 4: depth of the outstanding-command queue.
- `LINE_DEPTH`, 2: depth of the assembled-line FIFO.

Ports:
- `CLK` in 1: single clock. All logic is synchronous to its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `rd_en` in 1: one-cycle pulse from `dram_command` when a READ CAS is issued.
- `rd_tag` in TAG_W: tag of that read; sampled when `rd_en`=1.
- `rd_col` in log2(BURST_LEN): low column bits (`col_0`) of that read; sampled when `rd_en`=1.
- `beat_valid` in 1: `data_transfer` presents one read beat this cycle.
- `beat_data` in 32: beat payload, concatenated across the x8 chips.
- `line_valid` out 1: an assembled line is available.
- `line_data` out 32*BURST_LEN: assembled line; slot k occupies bits [32k+31:32k].
- `line_tag` out TAG_W: tag of the presented line.
- `line_ready` in 1: requester accepts the line.
- `rd_credit` out 1: `dram_command` may issue another READ.
- `err_unexp` out 1: sticky; a beat arrived with no outstanding command.
- `err_ovf` out 1: sticky; a command was dropped or a line was lost.

## Operation
- Command queue (CQ): a FIFO of {tag, col} entries.
  - `rd_en` pushes one entry.
  - A push into a full CQ drops the command and sets `err_ovf`.
- Assembly state machine:
  - IDLE: `beat_cnt`=0. A `beat_valid` with CQ non-empty stores the beat and moves to COLLECT (or, if BURST_LEN were 1, completes immediately).
  - COLLECT: each `beat_valid` stores one beat and increments `beat_cnt`.
  - The beat with `beat_cnt`=BURST_LEN-1 completes the line: the line is written with the CQ head tag, the CQ is popped, and the machine returns to IDLE.
  - Cycles with `beat_valid`=0 hold state; gaps between beats are legal.
- `beat_valid` with CQ empty: the beat is discarded, `err_unexp` is set, and the state is unchanged.
- Slot mapping: beat i of a burst is written to slot i, unless modified by the Configuration option below.
- Line FIFO (LF):
  - Push on line completion.
  - Pop when `line_valid` && `line_ready`.
  - Push and pop in the same cycle on a full LF is legal; the count is unchanged.
  - Push on a full LF without a simultaneous pop drops the line and sets `err_ovf`.
- Credit: `rd_credit` = (cq_count + lf_count) < LINE_DEPTH, evaluated combinationally from registered counts.
- Same-cycle `rd_en` and line completion: the CQ count is unchanged. The new command is queued behind the current head.
- Reset:
  - Clears CQ, LF, `beat_cnt`, and both error flags; partial lines are discarded.
  - Output values in reset: `line_valid`=0, `line_data`=0, `line_tag`=0, `rd_credit`=1, `err_unexp`=0, `err_ovf`=0.
  - `RST` asserted mid-burst takes priority over all other inputs in that cycle.

## Timing
- `rd_en` at cycle N: the CQ entry is visible at N+1. A beat at N+1 may therefore consume it.
- Last beat at cycle N: `line_valid`=1 with data and tag at N+1 (1-cycle latency), provided the LF was empty.
- `line_data` and `line_tag` are stable while `line_valid` && !`line_ready`.
- After a pop at N, the next LF entry is presented at N+1.
- `rd_credit` falls in the cycle after the `rd_en` that exhausts capacity.
- `rd_credit` rises in the cycle after the LF pop that frees capacity.
- Throughput: one beat per cycle sustained. Back-to-back bursts need no idle cycle.

## Configuration
- Macro: `RD_ASM_CRITICAL_WORD_FIRST_EN`.
- Defined:
  - DDR4 returns a burst starting at column `rd_col`. Beat i is written to slot (col + i) mod BURST_LEN, where col is the CQ-head col.
  - The wrap uses log2(BURST_LEN)-bit modulo arithmetic.
  - `line_data` is always in natural column order.
- Undefined:
  - `rd_col` is ignored and its CQ field is not stored.
  - Beat i goes to slot i.

## Test plan
- Basic read: after reset, `rd_en` with tag 3, col 0; then 8 consecutive beats 0x11111111..0x88888888 -> `line_valid` the cycle after the last beat, slot0=0x11111111, slot7=0x88888888, `line_tag`=3. `line_ready`=1 pops it.
- Critical word first (macro defined): `rd_col`=5; beats B0..B7 -> slot5=B0, slot7=B2, slot0=B3, slot4=B7. With the macro undefined, slot0=B0.
- Backpressure and credit:
  - Two reads issued, 16 beats delivered, `line_ready` held 0 -> both lines held and `rd_credit`=0.
  - Then `line_ready`=1 -> tags pop in issue order and `rd_credit`=1 one cycle after the first pop.
- Unexpected beat: `beat_valid` with no command -> beat ignored, `err_unexp`=1 persists until `RST`. A subsequent normal read still assembles correctly.
- Overflow: 5 `rd_en` pulses with CQ_DEPTH=4 and no beats -> `err_ovf`=1, CQ count=4.
- Reset mid-burst: `RST` after 4 of 8 beats -> all outputs at reset values, `rd_credit`=1. A fresh 8-beat read then produces a clean line with no stale beats.
